// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the two-paddle ball game controller.
//   game_state_t : controller state encoding, also exported on the state port
//   SCREEN_W/H   : visible playfield size in pixels (800x600)
//   SCORE_W      : score register width (scores 0..15)
//   BALL_Y_W     : width of the ball row coordinate
//   cnt_width()  : minimum counter width able to hold 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_POINT  = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } game_state_t;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam int SCORE_W  = 4;
    localparam int BALL_Y_W = 10;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// One-cycle rising-edge detector for a synchronous push-button level.
// A level held high yields a single pulse; a new pulse needs at least one
// sampled low cycle in between.
//   clk   : system clock
//   rst   : synchronous active-high reset (clears the history register)
//   level : synchronous button level
//   rise  : high for the cycle in which level is 1 and was 0 on the last edge
// ---------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // Combinational so the consuming FSM reacts on the very edge that
    // samples the new level; the FSM's own outputs are what get registered.
    assign rise = level & ~level_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game-sequencing controller around the ball motion datapath: waits for a
// serve, enables ball motion once per game tick, detects a missed ball at the
// top or bottom edge, awards the point, pauses, reloads the ball and declares
// the winner.
//
// Optional feature: define GAME_PAUSE_EN to enable the pause toggle. Without
// it the pause port is accepted but ignored and PAUSED is never entered.
//
// Ports
//   clk        : system clock
//   rst        : synchronous active-high reset
//   serve      : serve/restart button level (rising edge used)
//   pause      : pause toggle button level (rising edge used, GAME_PAUSE_EN)
//   ball_y     : current ball row from the motion block
//   move_en    : one-cycle step pulse to the motion block, once per tick in PLAY
//   ball_load  : one-cycle strobe, motion block reloads the centre position
//   serve_dir  : vertical start direction applied with ball_load (1 = down)
//   score_bot  : bottom player's score
//   score_top  : top player's score
//   game_over  : high in OVER
//   winner     : 1 = bottom player won, valid while game_over is high
//   state      : current state encoding for display/debug
//
// State table
//   state  | meaning
//   IDLE   | after reset, scores 0, waiting for first serve (loads the ball)
//   SERVE  | ball loaded at centre, waiting for a serve edge to launch
//   PLAY   | ball moving, move_en pulses on every tick, miss detection live
//   POINT  | point awarded, holding POINT_TICKS ticks before reload/game end
//   OVER   | a player reached WIN_SCORE, serve edge restarts the match
//   PAUSED | play frozen, tick counter held (GAME_PAUSE_EN only)
// ---------------------------------------------------------------------------
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int T_TICK      = 500_000,
    parameter int MISS_TOP    = 1,
    parameter int MISS_BOT    = SCREEN_H - 2,
    parameter int POINT_TICKS = 100,
    parameter int WIN_SCORE   = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serve,
    input  logic                pause,
    input  logic [BALL_Y_W-1:0] ball_y,
    output logic                move_en,
    output logic                ball_load,
    output logic                serve_dir,
    output logic [SCORE_W-1:0]  score_bot,
    output logic [SCORE_W-1:0]  score_top,
    output logic                game_over,
    output logic                winner,
    output logic [2:0]          state
);

    localparam int TICK_W = cnt_width(T_TICK);
    localparam int PT_W   = cnt_width(POINT_TICKS);

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(T_TICK - 1);
    localparam logic [PT_W-1:0]     PT_LAST   = PT_W'(POINT_TICKS - 1);
    localparam logic [SCORE_W-1:0]  WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [BALL_Y_W-1:0] Y_TOP     = BALL_Y_W'(MISS_TOP);
    localparam logic [BALL_Y_W-1:0] Y_BOT     = BALL_Y_W'(MISS_BOT);

    game_state_t       st;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              tick_run;
    logic [PT_W-1:0]   point_cnt;
    logic              serve_rise;
    logic              pause_rise;
    logic              pause_go;
    logic              bot_won;
    logic              top_won;

    btn_edge u_serve_edge (
        .clk   (clk),
        .rst   (rst),
        .level (serve),
        .rise  (serve_rise)
    );

    btn_edge u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .level (pause),
        .rise  (pause_rise)
    );

`ifdef GAME_PAUSE_EN
    assign pause_go = pause_rise;
    assign tick_run = (st != ST_PAUSED);
`else
    logic unused_pause;
    assign unused_pause = pause_rise;
    assign pause_go     = 1'b0;
    assign tick_run     = 1'b1;
`endif

    // Free-running tick timer; only held while the game is paused so that a
    // resume continues the interrupted tick instead of starting a fresh one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_run) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign tick    = (tick_cnt == TICK_LAST);
    assign bot_won = (score_bot == WIN);
    assign top_won = (score_top == WIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            move_en   <= 1'b0;
            ball_load <= 1'b0;
            serve_dir <= 1'b1;
            score_bot <= '0;
            score_top <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            point_cnt <= '0;
        end else begin
            move_en   <= 1'b0;
            ball_load <= 1'b0;

            case (st)
                ST_IDLE: begin
                    score_bot <= '0;
                    score_top <= '0;
                    if (serve_rise) begin
                        ball_load <= 1'b1;
                        serve_dir <= 1'b1;
                        st        <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (serve_rise) begin
                        st <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    // Pause is taken before miss detection: the ball is frozen
                    // while paused, so a pending miss is still seen on resume.
                    // move_en is only raised when PLAY is kept, so it can never
                    // appear in the cycle after the state has moved on.
                    if (pause_go) begin
                        st <= ST_PAUSED;
                    end else if (ball_y <= Y_TOP) begin
                        if (!bot_won) begin
                            score_bot <= score_bot + 1'b1;
                        end
                        serve_dir <= 1'b0;
                        point_cnt <= '0;
                        st        <= ST_POINT;
                    end else if (ball_y >= Y_BOT) begin
                        if (!top_won) begin
                            score_top <= score_top + 1'b1;
                        end
                        serve_dir <= 1'b1;
                        point_cnt <= '0;
                        st        <= ST_POINT;
                    end else begin
                        move_en <= tick;
                    end
                end

                ST_POINT: begin
                    // The partial tick in progress on entry is the first one.
                    if (tick) begin
                        if (point_cnt == PT_LAST) begin
                            if (bot_won || top_won) begin
                                game_over <= 1'b1;
                                winner    <= bot_won;
                                st        <= ST_OVER;
                            end else begin
                                ball_load <= 1'b1;
                                st        <= ST_SERVE;
                            end
                        end else begin
                            point_cnt <= point_cnt + 1'b1;
                        end
                    end
                end

                ST_OVER: begin
                    if (serve_rise) begin
                        score_bot <= '0;
                        score_top <= '0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                        ball_load <= 1'b1;
                        st        <= ST_SERVE;
                    end
                end

                ST_PAUSED: begin
                    if (pause_go) begin
                        st <= ST_PLAY;
                    end
                end

                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serve = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] ball_y = 10'd300;
    logic       move_en;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score_bot;
    logic [3:0] score_top;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    pong_game_ctrl #(
        .T_TICK      (4),
        .MISS_TOP    (1),
        .MISS_BOT    (598),
        .POINT_TICKS (2),
        .WIN_SCORE   (9)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serve     (serve),
        .pause     (pause),
        .ball_y    (ball_y),
        .move_en   (move_en),
        .ball_load (ball_load),
        .serve_dir (serve_dir),
        .score_bot (score_bot),
        .score_top (score_top),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic serve_pulse();
        serve = 1'b1;
        step();
        serve = 1'b0;
    endtask

    // Drive a miss row for one cycle, then wait for the end of POINT.
    // Tick counter after edge n is n mod 4; POINT ends on the edge that
    // samples the second tick seen in POINT.
    task automatic miss_and_wait(input logic [9:0] y, input string tag);
        int m;
        int exp_w;
        int w;
        bit done;
        ball_y = y;
        step();
        ball_y = 10'd300;
        m = cyc;
        exp_w = ((7 - (m % 4)) % 4) + 5;
        chk({tag, "_state_point"}, state, 3);
        chk({tag, "_move_en_point"}, move_en, 0);
        done = 1'b0;
        w = 0;
        for (int k = 1; k <= 12 && !done; k++) begin
            step();
            w = k;
            if (ball_load || game_over) done = 1'b1;
            else chk({tag, "_move_en_hold"}, move_en, 0);
        end
        chk({tag, "_point_len"}, w, exp_w);
    endtask

    initial begin
        int first;
        int highs;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        chk("rst_state", state, 0);
        chk("rst_move_en", move_en, 0);
        chk("rst_ball_load", ball_load, 0);
        chk("rst_serve_dir", serve_dir, 1);
        chk("rst_score_bot", score_bot, 0);
        chk("rst_score_top", score_top, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);

        // First serve loads the ball
        serve_pulse();
        chk("serve1_ball_load", ball_load, 1);
        chk("serve1_dir", serve_dir, 1);
        chk("serve1_state", state, 1);
        step();
        chk("serve1_load_once", ball_load, 0);
        chk("serve1_state_hold", state, 1);
        chk("serve1_scores", {score_bot, score_top}, 0);

        // Launch, move_en once per 4 cycles
        serve_pulse();
        chk("play_state", state, 2);
        chk("play_ball_load", ball_load, 0);
        first = 0;
        for (int k = 1; k <= 4 && first == 0; k++) begin
            step();
            if (move_en) first = k;
        end
        chk("move_en_seen", (first != 0), 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("move_en_period", move_en, ((k % 4) == 0));
            chk("play_no_load", ball_load, 0);
        end

        // Bottom miss
        miss_and_wait(10'd599, "bot_miss");
        chk("bot_miss_load", ball_load, 1);
        chk("bot_miss_dir", serve_dir, 1);
        chk("bot_miss_score_top", score_top, 1);
        chk("bot_miss_state", state, 1);

        // Top miss
        serve_pulse();
        chk("play2_state", state, 2);
        miss_and_wait(10'd0, "top_miss");
        chk("top_miss_load", ball_load, 1);
        chk("top_miss_dir", serve_dir, 0);
        chk("top_miss_score_bot", score_bot, 1);
        chk("top_miss_score_top", score_top, 1);

        // Bottom misses up to 9
        for (int i = 2; i <= 9; i++) begin
            serve_pulse();
            chk("loop_play", state, 2);
            miss_and_wait(10'd598, "loop_miss");
            chk("loop_score_top", score_top, i);
            chk("loop_ball_load", ball_load, (i < 9));
            chk("loop_game_over", game_over, (i == 9));
        end
        chk("over_state", state, 4);
        chk("over_winner", winner, 0);
        chk("over_score_bot", score_bot, 1);
        step();
        chk("over_hold", state, 4);

        // Restart from OVER
        serve_pulse();
        chk("restart_load", ball_load, 1);
        chk("restart_state", state, 1);
        chk("restart_scores", {score_bot, score_top}, 0);
        chk("restart_game_over", game_over, 0);

        // Serve ignored in PLAY
        step();
        serve_pulse();
        chk("play3_state", state, 2);
        step();
        serve_pulse();
        chk("serve_ignored_play", state, 2);
        chk("serve_ignored_load", ball_load, 0);
        step();

        // Pause
        pause = 1'b1;
        step();
        pause = 1'b0;
`ifdef GAME_PAUSE_EN
        chk("pause_state", state, 5);
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (move_en) highs++;
        end
        chk("pause_no_move", highs, 0);
        chk("pause_hold", state, 5);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("resume_state", state, 2);
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (move_en) highs++;
        end
        chk("resume_move", highs, 1);
`else
        chk("pause_ignored", state, 2);
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (move_en) highs++;
        end
        chk("pause_ignored_move", highs, 2);
`endif

        // Reset mid-POINT
        ball_y = 10'd599;
        step();
        ball_y = 10'd300;
        chk("pre_rst_state", state, 3);
        chk("pre_rst_score_top", score_top, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_scores", {score_bot, score_top}, 0);
        chk("midrst_serve_dir", serve_dir, 1);
        chk("midrst_ball_load", ball_load, 0);
        chk("midrst_move_en", move_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
